// File: rtl/pulse_handshake_tx.sv
// Source end of a 4-phase req/ack pulse-crossing channel: queues event pulses and runs one handshake per event.
// Optional payload FIFO is enabled by defining PHS_DATA_EN.
module pulse_handshake_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 8,
  parameter int DW          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_pulse,
  input  logic                     ack_async,
  output logic                     req,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pend_cnt,
  output logic                     done,
  output logic                     ovf
`ifdef PHS_DATA_EN
  ,
  input  logic [DW-1:0]            data_in,
  output logic [DW-1:0]            data_out
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   launch;
  logic                   accept;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // A launch frees a slot in the same cycle, so a full queue can still accept then.
  always_comb begin
    launch = 1'b0;
    accept = 1'b0;
    if (state == IDLE && pend_cnt != {CW{1'b0}}) begin
      launch = 1'b1;
    end else begin
      launch = 1'b0;
    end
    if (in_pulse && (pend_cnt < FULL || launch)) begin
      accept = 1'b1;
    end else begin
      accept = 1'b0;
    end
  end

  // Ack synchronizer chain; only its last stage is ever used.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};
    end
  end

  // Pending-event counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= {CW{1'b0}};
      ovf      <= 1'b0;
    end else begin
      case ({accept, launch})
        2'b10:   pend_cnt <= pend_cnt + CW'(1);
        2'b01:   pend_cnt <= pend_cnt - CW'(1);
        default: pend_cnt <= pend_cnt;
      endcase
      if (in_pulse && !accept) begin
        ovf <= 1'b1;
      end else begin
        ovf <= ovf;
      end
    end
  end

  // Handshake FSM with registered req/busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state <= REQ;
            req   <= 1'b1;
            busy  <= 1'b1;
          end else begin
            req  <= 1'b0;
            busy <= 1'b0;
          end
        end
        REQ: begin
          if (ack_s) begin
            state <= RELEASE;
            req   <= 1'b0;
          end else begin
            req <= 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RELEASE;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHS_DATA_EN
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Payload storage; dropped events never write.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= data_in;
    end
  end

  // FIFO pointers and the payload held for the transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= {AW{1'b0}};
      rptr     <= {AW{1'b0}};
      data_out <= {DW{1'b0}};
    end else begin
      if (accept) begin
        wptr <= wptr + AW'(1);
      end else begin
        wptr <= wptr;
      end
      if (launch) begin
        rptr     <= rptr + AW'(1);
        data_out <= mem[rptr];
      end else begin
        rptr     <= rptr;
        data_out <= data_out;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// Directed self-checking bench for pulse_handshake_tx (DEPTH=8, SYNC_STAGES=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pulse_handshake_tx;

  logic       clk;
  logic       rst;
  logic       in_pulse;
  logic       ack_async;
  logic       req;
  logic       busy;
  logic [3:0] pend_cnt;
  logic       done;
  logic       ovf;
`ifdef PHS_DATA_EN
  logic [7:0] data_in;
  logic [7:0] data_out;
`endif

  int tests;
  int fails;
  int rises;
  int dones;
  logic req_q;
  logic ack_man;
  logic auto_ack;
  logic [2:0] ack_dly;

  pulse_handshake_tx #(.SYNC_STAGES(2), .DEPTH(8), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pulse  (in_pulse),
    .ack_async (ack_async),
    .req       (req),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .done      (done),
    .ovf       (ovf)
`ifdef PHS_DATA_EN
    ,
    .data_in   (data_in),
    .data_out  (data_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Destination model: either a manual level or req delayed by 3 cycles.
  assign ack_async = auto_ack ? ack_dly[2] : ack_man;

  always @(posedge clk) begin
    ack_dly <= {ack_dly[1:0], req};
    req_q   <= req;
    if (req && !req_q) rises <= rises + 1;
    if (done) dones <= dones + 1;
  end

  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && !req && pend_cnt == 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_pulse = 1'b1; ack_man = 1'b1; auto_ack = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (pend_cnt !== 4'd0) begin fails++; $display("FAIL reset_pend got %0d want 0", pend_cnt); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b0; in_pulse = 1'b0; ack_man = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (pend_cnt !== 4'd0 || req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset_idle pend=%0d req=%b busy=%b want 0 0 0", pend_cnt, req, busy);
    end
  endtask

  task automatic test_single();
    int d0;
    bit seen;
    d0 = dones;
    in_pulse = 1'b1;
    @(negedge clk);
    in_pulse = 1'b0;
    tests++; if (pend_cnt !== 4'd1 || req !== 1'b0) begin
      fails++; $display("FAIL single_t1 pend=%0d req=%b want 1 0", pend_cnt, req);
    end
    @(negedge clk);
    tests++; if (req !== 1'b1 || pend_cnt !== 4'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_t2 req=%b pend=%0d busy=%b want 1 0 1", req, pend_cnt, busy);
    end
    repeat (3) @(negedge clk);
    ack_man = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!req) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL single_req_fall got req=%b want 0 within 10 cycles", req); end
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL single_release busy=%b done=%b want 1 0", busy, done);
    end
    repeat (3) @(negedge clk);
    ack_man = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL single_done got done=%b want pulse within 10 cycles", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_at_done got %b want 0", busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_done_width got %b want 0", done); end
    tests++; if (dones - d0 !== 1) begin fails++; $display("FAIL single_done_count got %0d want 1", dones - d0); end
  endtask

  task automatic test_burst();
    int r0, d0;
    bit ok;
    r0 = rises; d0 = dones;
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_pulse = 1'b1;
      @(negedge clk);
    end
    in_pulse = 1'b0;
    wait_idle(400, ok);
    repeat (2) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL burst_timeout busy=%b pend=%0d want idle", busy, pend_cnt); end
    tests++; if (rises - r0 !== 5) begin fails++; $display("FAIL burst_rises got %0d want 5", rises - r0); end
    tests++; if (dones - d0 !== 5) begin fails++; $display("FAIL burst_dones got %0d want 5", dones - d0); end
    tests++; if (ovf !== 1'b0 || pend_cnt !== 4'd0) begin
      fails++; $display("FAIL burst_end ovf=%b pend=%0d want 0 0", ovf, pend_cnt);
    end
    auto_ack = 1'b0; ack_man = 1'b0;
  endtask

  task automatic test_overflow();
    int r0, d0;
    bit ok;
    repeat (3) @(negedge clk);
    r0 = rises; d0 = dones;
    for (int i = 0; i < 12; i++) begin
      in_pulse = 1'b1;
      @(negedge clk);
    end
    in_pulse = 1'b0;
    tests++; if (pend_cnt !== 4'd8) begin fails++; $display("FAIL ovf_pend got %0d want 8", pend_cnt); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", ovf); end
    tests++; if (req !== 1'b1 || rises - r0 !== 1) begin
      fails++; $display("FAIL ovf_launched req=%b rises=%0d want 1 1", req, rises - r0);
    end
    auto_ack = 1'b1;
    wait_idle(800, ok);
    repeat (2) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_timeout busy=%b pend=%0d want idle", busy, pend_cnt); end
    tests++; if (dones - d0 !== 9 || rises - r0 !== 9) begin
      fails++; $display("FAIL ovf_handshakes dones=%0d rises=%0d want 9 9", dones - d0, rises - r0);
    end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    auto_ack = 1'b0; ack_man = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_pulse = 1'b1;
      @(negedge clk);
    end
    in_pulse = 1'b0;
    tests++; if (req !== 1'b1 || pend_cnt !== 4'd3) begin
      fails++; $display("FAIL mid_setup req=%b pend=%0d want 1 3", req, pend_cnt);
    end
    rst = 1'b1; ack_man = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (req !== 1'b0 || pend_cnt !== 4'd0 || busy !== 1'b0 || ovf !== 1'b0) begin
      fails++; $display("FAIL mid_reset req=%b pend=%0d busy=%b ovf=%b want 0 0 0 0", req, pend_cnt, busy, ovf);
    end
    d0 = dones;
    repeat (6) @(negedge clk);
    tests++; if (req !== 1'b0 || busy !== 1'b0 || dones - d0 !== 0) begin
      fails++; $display("FAIL mid_stale_ack req=%b busy=%b dones=%0d want 0 0 0", req, busy, dones - d0);
    end
    ack_man = 1'b0;
    repeat (4) @(negedge clk);
    auto_ack = 1'b1;
    in_pulse = 1'b1;
    @(negedge clk);
    in_pulse = 1'b0;
    wait_idle(100, ok);
    repeat (2) @(negedge clk);
    tests++; if (!ok || dones - d0 !== 1) begin
      fails++; $display("FAIL mid_recover ok=%b dones=%0d want 1 1", ok, dones - d0);
    end
    auto_ack = 1'b0;
  endtask

`ifdef PHS_DATA_EN
  task automatic test_data();
    logic [7:0] exp_q [3];
    logic [7:0] cur;
    logic prev_req;
    int idx;
    exp_q[0] = 8'hA1; exp_q[1] = 8'hB2; exp_q[2] = 8'hC3;
    repeat (3) @(negedge clk);
    auto_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pulse = 1'b1; data_in = exp_q[i];
      @(negedge clk);
    end
    in_pulse = 1'b0; data_in = 8'h00;
    idx = 0; prev_req = 1'b0; cur = 8'h00;
    for (int c = 0; c < 300 && !(idx == 3 && !busy); c++) begin
      if (req && !prev_req) begin
        tests++; if (idx > 2 || data_out !== exp_q[idx]) begin
          fails++; $display("FAIL data_rise%0d got %h want %h", idx, data_out, exp_q[idx < 3 ? idx : 2]);
        end
        cur = data_out;
        idx++;
      end else if (busy && data_out !== cur) begin
        tests++; fails++; $display("FAIL data_stable got %h want %h", data_out, cur);
      end
      prev_req = req;
      @(negedge clk);
    end
    tests++; if (idx !== 3) begin fails++; $display("FAIL data_count got %0d want 3", idx); end
    auto_ack = 1'b0;
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; in_pulse = 1'b0; ack_man = 1'b0; auto_ack = 1'b0;
`ifdef PHS_DATA_EN
    data_in = 8'h00;
`endif
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid();
`ifdef PHS_DATA_EN
    test_data();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rises = 0; dones = 0; req_q = 1'b0; ack_dly = 3'b000;
  end

endmodule
